// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core.
// Runs an instruction through fetch, decode, execute, memory and writeback.
// Drives the datapath strobes and operand selects, and owns one shared
// memory request/ready handshake. Illegal opcodes and memory requests that
// never get an answer put the FSM into a sticky trap state. The block also
// counts retired instructions.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE    = 3'd0,
    C_R       = 3'd1,
    C_IALU    = 3'd2,
    C_LUI     = 3'd3,
    C_AUIPC   = 3'd4,
    C_LOAD    = 3'd5,
    C_STORE   = 3'd6,
    C_ILLEGAL = 3'd7
  } class_t;

  // Map the opcode and funct3 to an operation class. LOAD and STORE also
  // check funct3, because only some widths are legal for them.
  function automatic class_t decode_class(input logic [6:0] op, input logic [2:0] f3);
    class_t cls;
    case (op)
      7'b0110011: cls = C_R;
      7'b0010011: cls = C_IALU;
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      7'b0000011: begin
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: cls = C_LOAD;
          default:                                 cls = C_ILLEGAL;
        endcase
      end
      7'b0100011: begin
        case (f3)
          3'b000, 3'b001, 3'b010: cls = C_STORE;
          default:                cls = C_ILLEGAL;
        endcase
      end
      default: cls = C_ILLEGAL;
    endcase
    return cls;
  endfunction

  state_t            r_state;
  class_t            r_class;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_trap;
  logic [1:0]        r_trap_cause;
  logic [31:0]       r_instret;

  state_t            w_next_state;
  class_t            w_dec_class;
  logic              w_req_state;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_timeout;
  logic              w_sel_a_cls;
  logic              w_sel_b_cls;
  logic              w_mem_req;
  logic              w_mem_we;
  logic              w_mem_sel;
  logic              w_ir_we;
  logic              w_pc_we;
  logic              w_rf_we;
  logic              w_src_a;
  logic              w_src_b;
  logic [1:0]        w_wb_sel;
  logic              w_retire;
  logic [1:0]        w_new_cause;

  assign w_dec_class = decode_class(opcode, funct3);
  assign w_sel_a_cls = (r_class == C_AUIPC);
  assign w_sel_b_cls = (r_class == C_IALU) || (r_class == C_LOAD) ||
                       (r_class == C_STORE) || (r_class == C_AUIPC);

  // The memory is requested only in FETCH and MEM. A timeout fires on the
  // unanswered cycle whose count reaches the limit, so TRAP appears on the
  // following cycle.
  assign w_req_state = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_wait_inc  = r_wait_cnt + WAIT_ONE;
  assign w_timeout   = w_req_state && !mem_ready && (w_wait_inc == WAIT_LIMIT);

  // Next-state, strobe and operand-select decode from state, class and mem_ready
  always_comb begin
    w_next_state = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_sel    = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_rf_we      = 1'b0;
    w_src_a      = 1'b0;
    w_src_b      = 1'b0;
    w_wb_sel     = 2'b00;
    w_retire     = 1'b0;
    w_new_cause  = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_we      = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_new_cause  = 2'b10;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_dec_class == C_ILLEGAL) begin
          w_next_state = S_TRAP;
          w_new_cause  = 2'b01;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        w_src_a = w_sel_a_cls;
        w_src_b = w_sel_b_cls;
        if ((r_class == C_LOAD) || (r_class == C_STORE)) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        w_src_a   = w_sel_a_cls;
        w_src_b   = w_sel_b_cls;
        w_mem_req = 1'b1;
        w_mem_sel = 1'b1;
        w_mem_we  = (r_class == C_STORE);
        if (mem_ready) begin
          if (r_class == C_STORE) begin
            w_pc_we      = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_WB;
          end
        end else if (w_timeout) begin
          w_next_state = S_TRAP;
          w_new_cause  = 2'b10;
        end else begin
          w_next_state = S_MEM;
        end
      end
      S_WB: begin
        w_src_a      = w_sel_a_cls;
        w_src_b      = w_sel_b_cls;
        w_rf_we      = 1'b1;
        w_pc_we      = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
        if (r_class == C_LOAD) begin
          w_wb_sel = 2'b01;
        end else if (r_class == C_LUI) begin
          w_wb_sel = 2'b10;
        end else begin
          w_wb_sel = 2'b00;
        end
      end
      S_TRAP: begin
        w_next_state = S_TRAP;
      end
      default: begin
        w_next_state = S_TRAP;
      end
    endcase
  end

  // State, class, wait counter, trap flags and retire counter, with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_class      <= C_NONE;
      r_wait_cnt   <= WAIT_ZERO;
      r_trap       <= 1'b0;
      r_trap_cause <= 2'b00;
      r_instret    <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        r_class <= w_dec_class;
      end else begin
        r_class <= r_class;
      end
      if (w_next_state != r_state) begin
        r_wait_cnt <= WAIT_ZERO;
      end else if (w_req_state && !mem_ready) begin
        r_wait_cnt <= w_wait_inc;
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
      if ((w_next_state == S_TRAP) && (r_state != S_TRAP)) begin
        r_trap       <= 1'b1;
        r_trap_cause <= w_new_cause;
      end else begin
        r_trap       <= r_trap;
        r_trap_cause <= r_trap_cause;
      end
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
      end else begin
        r_instret <= r_instret;
      end
    end
  end

  // While reset is held, the side-effecting strobes are gated off so that
  // a request in flight is abandoned cleanly.
  assign mem_req    = w_mem_req & ~rst;
  assign ir_we      = w_ir_we & ~rst;
  assign pc_we      = w_pc_we & ~rst;
  assign rf_we      = w_rf_we & ~rst;
  assign mem_we     = w_mem_we;
  assign mem_sel    = w_mem_sel;
  assign alu_src_a  = w_src_a;
  assign alu_src_b  = w_src_b;
  assign wb_sel     = w_wb_sel;
  assign state      = r_state;
  assign trap       = r_trap;
  assign trap_cause = r_trap_cause;
  assign instret    = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl. It has two instances
// that share the same inputs: one uses the default timeout and one uses
// MEM_TIMEOUT=4.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        rdy;
    logic [47:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        mem_ready;

  logic        mem_req, mem_we, mem_sel, ir_we, pc_we, rf_we, alu_src_a, alu_src_b;
  logic [1:0]  wb_sel, trap_cause;
  logic [2:0]  state;
  logic        trap;
  logic [31:0] instret;

  logic        t_mem_req, t_mem_we, t_mem_sel, t_ir_we, t_pc_we, t_rf_we, t_alu_src_a, t_alu_src_b;
  logic [1:0]  t_wb_sel, t_trap_cause;
  logic [2:0]  t_state;
  logic        t_trap;
  logic [31:0] t_instret;

  logic [47:0] act;
  logic [47:0] act_t;

  int n_checks;
  int n_fail;
  vec_t tv[$];

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_we(ir_we),
    .pc_we(pc_we), .rf_we(rf_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .wb_sel(wb_sel), .state(state), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_t (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_sel(t_mem_sel), .ir_we(t_ir_we),
    .pc_we(t_pc_we), .rf_we(t_rf_we), .alu_src_a(t_alu_src_a), .alu_src_b(t_alu_src_b),
    .wb_sel(t_wb_sel), .state(t_state), .trap(t_trap), .trap_cause(t_trap_cause),
    .instret(t_instret)
  );

  assign act   = {state, mem_req, mem_we, mem_sel, ir_we, pc_we, rf_we, alu_src_a,
                  alu_src_b, wb_sel, trap, trap_cause, instret};
  assign act_t = {t_state, t_mem_req, t_mem_we, t_mem_sel, t_ir_we, t_pc_we, t_rf_we,
                  t_alu_src_a, t_alu_src_b, t_wb_sel, t_trap, t_trap_cause, t_instret};

  // Free-running core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] pack(
    input logic [2:0] st, input logic req, input logic we, input logic sel,
    input logic ir, input logic pc, input logic rf, input logic sa, input logic sb,
    input logic [1:0] wb, input logic trp, input logic [1:0] cause, input logic [31:0] icnt);
    return {st, req, we, sel, ir, pc, rf, sa, sb, wb, trp, cause, icnt};
  endfunction

  function automatic vec_t mk(
    input logic r, input logic [6:0] op, input logic [2:0] f3, input logic rdy,
    input logic [2:0] st, input logic req, input logic we, input logic sel,
    input logic ir, input logic pc, input logic rf, input logic sa, input logic sb,
    input logic [1:0] wb, input logic trp, input logic [1:0] cause, input logic [31:0] icnt);
    vec_t v;
    v.rst = r; v.op = op; v.f3 = f3; v.rdy = rdy;
    v.exp = pack(st, req, we, sel, ir, pc, rf, sa, sb, wb, trp, cause, icnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, got, want);
    end
  endtask

  // Drive the inputs on the falling edge, then let the combinational outputs settle
  task automatic cycle(input logic r, input logic [6:0] op, input logic [2:0] f3, input logic rdy);
    @(negedge clk);
    rst = r; opcode = op; funct3 = f3; mem_ready = rdy;
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; opcode = OP_R; funct3 = 3'b000; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset and R-type: states 0,1,2,4, then retire
    //          rst   op        f3      rdy   st    req   we    sel   ir    pc    rf    sa    sb    wb     trp   cause  instret
    tv.push_back(mk(1'b1, OP_R,     3'b000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    tv.push_back(mk(1'b0, OP_R,     3'b000, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    tv.push_back(mk(1'b0, OP_R,     3'b000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    tv.push_back(mk(1'b0, OP_R,     3'b000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    tv.push_back(mk(1'b0, OP_R,     3'b000, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    // LOAD lw with 3 wait cycles in MEM
    tv.push_back(mk(1'b0, OP_LOAD,  3'b010, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd1));
    tv.push_back(mk(1'b0, OP_LOAD,  3'b010, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd1));
    tv.push_back(mk(1'b0, OP_LOAD,  3'b010, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'd1));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(1'b0, OP_LOAD, 3'b010, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'd1));
    tv.push_back(mk(1'b0, OP_LOAD,  3'b010, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'd1));
    tv.push_back(mk(1'b0, OP_LOAD,  3'b010, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 32'd1));
    // STORE sh, zero-wait: pc_we together with mem_we in MEM
    tv.push_back(mk(1'b0, OP_STORE, 3'b001, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd2));
    tv.push_back(mk(1'b0, OP_STORE, 3'b001, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd2));
    tv.push_back(mk(1'b0, OP_STORE, 3'b001, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'd2));
    tv.push_back(mk(1'b0, OP_STORE, 3'b001, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'd2));
    // LOAD lb, reset during the MEM wait
    tv.push_back(mk(1'b0, OP_LOAD,  3'b000, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd3));
    tv.push_back(mk(1'b0, OP_LOAD,  3'b000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd3));
    tv.push_back(mk(1'b0, OP_LOAD,  3'b000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'd3));
    tv.push_back(mk(1'b0, OP_LOAD,  3'b000, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'd3));
    tv.push_back(mk(1'b1, OP_LOAD,  3'b000, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'd3));
    tv.push_back(mk(1'b0, OP_AUIPC, 3'b000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    // AUIPC: both operand selects high
    tv.push_back(mk(1'b0, OP_AUIPC, 3'b000, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    tv.push_back(mk(1'b0, OP_AUIPC, 3'b000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    tv.push_back(mk(1'b0, OP_AUIPC, 3'b000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 32'd0));
    tv.push_back(mk(1'b0, OP_AUIPC, 3'b000, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00, 32'd0));
    // LUI: wb_sel=10, register operands
    tv.push_back(mk(1'b0, OP_LUI,   3'b000, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd1));
    tv.push_back(mk(1'b0, OP_LUI,   3'b000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd1));
    tv.push_back(mk(1'b0, OP_LUI,   3'b000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd1));
    tv.push_back(mk(1'b0, OP_LUI,   3'b000, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 32'd1));
    // LOAD with funct3=011 is illegal; TRAP holds while mem_ready toggles
    tv.push_back(mk(1'b0, OP_LOAD,  3'b011, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd2));
    tv.push_back(mk(1'b0, OP_LOAD,  3'b011, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd2));
    for (int i = 0; i < 20; i++)
      tv.push_back(mk(1'b0, OP_LOAD, 3'b011, logic'(i % 2), 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 32'd2));
    tv.push_back(mk(1'b1, OP_IALU,  3'b000, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 32'd2));
    // IALU after reset clears the trap
    tv.push_back(mk(1'b0, OP_IALU,  3'b000, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    tv.push_back(mk(1'b0, OP_IALU,  3'b000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    tv.push_back(mk(1'b0, OP_IALU,  3'b000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'd0));
    tv.push_back(mk(1'b0, OP_IALU,  3'b000, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'd0));
    // Opcode 1111111 is illegal
    tv.push_back(mk(1'b0, OP_BAD,   3'b000, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd1));
    tv.push_back(mk(1'b0, OP_BAD,   3'b000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd1));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(1'b0, OP_BAD, 3'b000, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 32'd1));

    foreach (tv[i]) begin
      cycle(tv[i].rst, tv[i].op, tv[i].f3, tv[i].rdy);
      chk($sformatf("vec%0d", i), act, tv[i].exp);
      chk($sformatf("vec%0d_t4", i), act_t, tv[i].exp);
    end

    // Fetch timeout with MEM_TIMEOUT=4: four request cycles, then TRAP cause 10
    cycle(1'b1, OP_R, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, OP_R, 3'b000, 1'b0);
      chk($sformatf("to_wait%0d", i), act_t,
          pack(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    end
    cycle(1'b0, OP_R, 3'b000, 1'b0);
    chk("to_trap", act_t,
        pack(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 32'd0));
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, OP_R, 3'b000, logic'(i % 2));
      chk($sformatf("to_hold%0d", i), act_t,
          pack(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 32'd0));
    end
    // The default-timeout instance has only waited 9 cycles with mem_ready low,
    // so it is still fetching; an odd cycle above answered it, though. Restart
    // it and wait 12 cycles with no answer.
    cycle(1'b1, OP_R, 3'b000, 1'b0);
    repeat (12) cycle(1'b0, OP_R, 3'b000, 1'b0);
    chk("no_timeout_default", act,
        pack(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));

    // Boundary: an answer on the 4th request cycle wins over the timeout
    cycle(1'b1, OP_R, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, OP_R, 3'b000, 1'b0);
      chk($sformatf("edge_wait%0d", i), act_t,
          pack(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    end
    cycle(1'b0, OP_R, 3'b000, 1'b1);
    chk("edge_ready", act_t,
        pack(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));
    cycle(1'b0, OP_R, 3'b000, 1'b0);
    chk("edge_decode", act_t,
        pack(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback around the instruction-field decoder. It consumes the decoded opcode/funct3 and drives the IR/PC/register-file write strobes, ALU operand selects and a single shared memory request/ready handshake. It also detects illegal opcodes and memory timeouts and counts retired instructions.

Parameters:
MEM_TIMEOUT, 255, max consecutive unanswered mem_req cycles before trap (>=1); wait counter width = $clog2(MEM_TIMEOUT+1)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
opcode  in  7  decoded instruction[6:0]
funct3  in  3  decoded instruction[14:12]
mem_ready  in  1  memory accepts/completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1 = store request
mem_sel  out  1  0 = instruction fetch, 1 = data access
ir_we  out  1  latch instruction register
pc_we  out  1  PC <= next PC
rf_we  out  1  register file write enable
alu_src_a  out  1  0 = rs1, 1 = PC (AUIPC)
alu_src_b  out  1  0 = rs2, 1 = immediate
wb_sel  out  2  00 = ALU, 01 = memory data, 10 = U-immediate (LUI)
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5
trap  out  1  sticky trap flag
trap_cause  out  2  00 none, 01 illegal instruction, 10 memory timeout
instret  out  32  retired-instruction counter, wraps at 2^32

Behaviour:
- Reset, sync: state=FETCH, trap=0, trap_cause=00, instret=0, wait counter=0, op class=none.
- While rst=1, mem_req, ir_we, pc_we and rf_we are forced 0.
- Outputs are combinational from state, registered op class and mem_ready. Strobes not listed for a state are 0.
- Op classes, captured into a register in DECODE:
  - R 0110011; IALU 0010011; LUI 0110111; AUIPC 0010111.
  - LOAD 0000011 legal for funct3 in {000,001,010,100,101}.
  - STORE 0100011 legal for funct3 in {000,001,010}.
  - Anything else is illegal.
- FETCH: mem_req=1, mem_sel=0, mem_we=0. On mem_ready: ir_we=1 in the same cycle, next state DECODE.
- DECODE: legal -> EXEC; illegal -> TRAP with trap_cause=01. No strobes.
- EXEC: single cycle. R/IALU/LUI/AUIPC -> WB; LOAD/STORE -> MEM.
- Operand selects are driven in EXEC, MEM and WB according to the captured class:
  - alu_src_b=1 for IALU/LOAD/STORE/AUIPC.
  - alu_src_a=1 for AUIPC only.
- MEM: mem_req=1, mem_sel=1, mem_we=1 for STORE only. On mem_ready:
  - STORE: pc_we=1, instret+1, -> FETCH.
  - LOAD: -> WB.
- WB: rf_we=1, pc_we=1, instret+1, -> FETCH.
  - wb_sel: 01 for LOAD, 10 for LUI, 00 otherwise.
- Instruction latency with zero-wait memory: 4 cycles for ALU/LUI/AUIPC, 5 for LOAD, 4 for STORE.
- Wait counter:
  - Clears on every state entry.
  - Increments each cycle with mem_req=1 and mem_ready=0.
  - When it equals MEM_TIMEOUT, the state goes to TRAP with trap_cause=10, so TRAP is visible in cycle MEM_TIMEOUT+1 of the request.
- mem_ready in DECODE/EXEC/WB/TRAP is ignored.
- TRAP: trap=1, all strobes 0, no exit except rst. trap_cause holds its first value.
- instret is unaffected by traps.
- rst mid-request (FETCH/MEM): request abandoned with no pc_we/rf_we; next cycle is FETCH with counters cleared.

Test Plan:
1. Reset, then opcode=0110011 with mem_ready=1 in every FETCH cycle -> states 0,1,2,4,0; ir_we 1 cycle; rf_we and pc_we 1 cycle each in WB with wb_sel=00; instret=1.
2. LOAD (opcode 0000011, funct3 010) with data mem_ready after 3 wait cycles -> mem_req=1, mem_sel=1, mem_we=0 for 4 MEM cycles; WB has wb_sel=01, rf_we=1; instret=1; 8 cycles total.
3. STORE (0100011, funct3 001), mem_ready=1 -> MEM has mem_we=1 and pc_we=1 in the same cycle; rf_we never asserted; instret increments; next state FETCH.
4. opcode=1111111, or LOAD with funct3=011 -> DECODE goes to TRAP; trap=1, trap_cause=01; no pc_we; remains in TRAP for 20 cycles despite mem_ready toggling.
5. MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> mem_req high 4 cycles, then state=5, trap_cause=10, mem_req=0.
6. 3 instructions retired, then rst=1 for 1 cycle during a MEM wait -> mem_req=0 in the rst cycle; next cycle state=0, instret=0, trap=0.
